// File: rtl/sap_isa_pkg.sv
// sap_isa_pkg: shared ISA constants for the SAP program encoder and the
// instruction decoder. It holds the opcode map, the mnemonic indices and the
// encoder FSM state encoding.
package sap_isa_pkg;

   // Opcode map (instruction word bits [7:4])
   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_CMP = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b0111;
   localparam logic [3:0] OP_STA = 4'b1000;
   localparam logic [3:0] OP_ADI = 4'b1100;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Mnemonic indices as presented on the mnem port; 11..15 are illegal
   localparam logic [3:0] MN_LDA = 4'd0;
   localparam logic [3:0] MN_ADD = 4'd1;
   localparam logic [3:0] MN_SUB = 4'd2;
   localparam logic [3:0] MN_XOR = 4'd3;
   localparam logic [3:0] MN_OR  = 4'd4;
   localparam logic [3:0] MN_CMP = 4'd5;
   localparam logic [3:0] MN_LDI = 4'd6;
   localparam logic [3:0] MN_STA = 4'd7;
   localparam logic [3:0] MN_ADI = 4'd8;
   localparam logic [3:0] MN_OUT = 4'd9;
   localparam logic [3:0] MN_HLT = 4'd10;

   // Encoder FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCEPT = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Program-RAM instruction word
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] operand;
   } instr_t;

endpackage

// File: rtl/opcode_lut.sv
// opcode_lut: combinational mnemonic-index to opcode lookup. Indices with no
// instruction assigned raise illegal and return opcode 0.
module opcode_lut
   import sap_isa_pkg::*;
(
   input  logic [3:0] mnem,
   output logic [3:0] opcode,
   output logic       illegal
);

   // Map each mnemonic index to its opcode; everything else is illegal
   always_comb begin
      opcode  = 4'b0000;
      illegal = 1'b0;
      case (mnem)
         MN_LDA:  opcode = OP_LDA;
         MN_ADD:  opcode = OP_ADD;
         MN_SUB:  opcode = OP_SUB;
         MN_XOR:  opcode = OP_XOR;
         MN_OR:   opcode = OP_OR;
         MN_CMP:  opcode = OP_CMP;
         MN_LDI:  opcode = OP_LDI;
         MN_STA:  opcode = OP_STA;
         MN_ADI:  opcode = OP_ADI;
         MN_OUT:  opcode = OP_OUT;
         MN_HLT:  opcode = OP_HLT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/program_encoder.sv
// program_encoder: takes mnemonic/operand pairs over a valid/ready handshake,
// encodes them into 8-bit instruction words and writes them into a 16-entry
// program RAM at consecutive addresses. A load ends on HLT or after address 15.
// Optional feature: define PROGRAM_ENCODER_CHECKSUM_EN to add an 8-bit running
// checksum of the words written during the current load.
module program_encoder
   import sap_isa_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] mnem,
   input  logic [3:0] operand,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       busy,
   output logic       done,
   output logic       err
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
   ,
   output logic [7:0] checksum
`endif
);

   logic [1:0] state;
   logic [3:0] addr_q;
   instr_t     word_q;
   logic       hlt_q;
   logic       err_q;

   logic [3:0] lut_opcode;
   logic       lut_illegal;

   // start is honoured only from IDLE or DONE; mid-load it is ignored
   logic       load_start;
   logic       xfer;

   opcode_lut u_lut (
      .mnem    (mnem),
      .opcode  (lut_opcode),
      .illegal (lut_illegal)
   );

   assign load_start = start && (state == ST_IDLE || state == ST_DONE);
   assign xfer       = in_valid && (state == ST_ACCEPT);

   // Load sequencer: handshake, one-cycle write, address advance, termination
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= ST_IDLE;
         addr_q <= 4'd0;
         word_q <= '0;
         hlt_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (load_start) begin
                  state  <= ST_ACCEPT;
                  addr_q <= 4'd0;
                  err_q  <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               if (xfer) begin
                  if (lut_illegal) begin
                     // dropped: no write, address held, keep accepting
                     err_q <= 1'b1;
                  end else begin
                     word_q <= '{opcode: lut_opcode, operand: operand};
                     hlt_q  <= (lut_opcode == OP_HLT);
                     state  <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               addr_q <= addr_q + 4'd1;
               state  <= (hlt_q || addr_q == 4'd15) ? ST_DONE : ST_ACCEPT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode straight from registered state so clr clears them at once
   assign in_ready  = (state == ST_ACCEPT);
   assign mem_we    = (state == ST_WRITE);
   assign busy      = (state == ST_ACCEPT) || (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign err       = err_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = word_q;

`ifdef PROGRAM_ENCODER_CHECKSUM_EN
   logic [7:0] sum_q;

   // Running mod-256 sum of each word as it is written
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sum_q <= 8'd0;
      end else if (load_start) begin
         sum_q <= 8'd0;
      end else if (state == ST_WRITE) begin
         sum_q <= sum_q + word_q;
      end
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: randomized scoreboard bench for program_encoder.
// The driver pushes the expected RAM writes from a reference model; a
// separate monitor pops and compares whenever mem_we is seen.
module tb_program_encoder;

   logic       clk = 1'b0;
   logic       clr;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] mnem;
   logic [3:0] operand;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       busy;
   logic       done;
   logic       err;
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   program_encoder dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mnem      (mnem),
      .operand   (operand),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // reference model state for the current load
   int   opc_tab[11] = '{'h0, 'h4, 'h2, 'h3, 'h5, 'h6, 'h7, 'h8, 'hC, 'hE, 'hF};
   int   wr_cnt;
   bit   ended;
   bit   exp_err;
   int   exp_sum;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: every write must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                     mem_addr, mem_wdata, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   task automatic begin_load();
      wr_cnt  = 0;
      ended   = 0;
      exp_err = 0;
      exp_sum = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Offer one pair after 'gap' idle cycles; optional stray start pulses mid-load
   task automatic send_pair(input int m, input int o, input int gap, input bit stray_start);
      bit ok;
      in_valid = 1'b0;
      repeat (gap) begin
         start = stray_start && ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (m <= 10) begin
         exp_t e;
         e.addr = wr_cnt % 16;
         e.data = (opc_tab[m] * 16 + o) % 256;
         exp_q.push_back(e);
         exp_sum = (exp_sum + e.data) % 256;
      end else begin
         exp_err = 1;
      end
      in_valid = 1'b1;
      mnem     = 4'(m);
      operand  = 4'(o);
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1;
         end
      end
      in_valid = 1'b0;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL handshake_timeout: got no in_ready expected in_ready within 50 cycles");
      end
      if (m <= 10) begin
         wr_cnt++;
         ended = (m == 10) || (wr_cnt == 16);
      end
   endtask

   task automatic finish_load();
      int  c;
      bit  got;
      c = 0;
      got = 0;
      while (c < 20 && !got) begin
         @(negedge clk);
         c++;
         if (done) got = 1;
      end
      chk("done_latency", c, 2);
      chk("done", done, 1);
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 0);
      chk("done_err", err, exp_err);
      chk("pending_writes", exp_q.size(), 0);
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
      chk("checksum", checksum, exp_sum);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      clr      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      mnem     = 4'd0;
      operand  = 4'd0;
      #3;
      check_all_zero("reset");
      #9;
      clr = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("idle");

      // Scenario 1: LDA 9, ADD 10, OUT 0, HLT 0
      begin_load();
      send_pair(0, 9, 0, 0);
      send_pair(1, 10, 1, 0);
      send_pair(9, 0, 0, 0);
      send_pair(10, 0, 2, 0);
      finish_load();

      // Scenario 2: 16 x LDI 5, ends at address 15 without HLT
      begin_load();
      for (int i = 0; i < 16; i++) send_pair(6, 5, 0, 0);
      finish_load();

      // Scenario 3: illegal mnemonic mid-load is dropped, err is sticky
      begin_load();
      send_pair(0, 1, 0, 0);
      send_pair(1, 2, 0, 0);
      send_pair(12, 3, 1, 0);
      chk("illegal_err", err, 1);
      chk("illegal_addr_held", mem_addr, 2);
      send_pair(9, 0, 0, 0);
      send_pair(10, 0, 0, 0);
      finish_load();

      // Scenario 5: clr during WRITE of address 3
      begin_load();
      send_pair(0, 1, 0, 0);
      send_pair(2, 2, 0, 0);
      send_pair(3, 3, 0, 0);
      send_pair(7, 4, 0, 0);
      chk("pre_clr_we", mem_we, 1);
      chk("pre_clr_addr", mem_addr, 3);
      clr = 1'b1;
      #1;
      check_all_zero("clr_abort");
      exp_q.delete();
      #10;
      clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         mnem     = 4'($urandom_range(0, 10));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_all_zero("post_clr_idle");

`ifdef PROGRAM_ENCODER_CHECKSUM_EN
      // Scenario 6: LDA 9, HLT 0 gives checksum 0xF9
      begin_load();
      send_pair(0, 9, 0, 0);
      send_pair(10, 0, 0, 0);
      finish_load();
      chk("checksum_f9", checksum, 8'hF9);
`endif

      // Scenario 4: random loads with gaps, illegal pairs and ignored starts
      for (int l = 0; l < 20; l++) begin
         begin_load();
         while (!ended) begin
            int m;
            m = $urandom_range(0, 15);
            if (m == 10 && $urandom_range(0, 1) == 0) m = 6;
            send_pair(m, $urandom_range(0, 15), $urandom_range(0, 3), 1);
         end
         finish_load();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
